// File: rtl/pmips_pkg.sv
// Shared definitions for the pmips datapath: ALU opcodes, word width and the
// saturation constant for signed fractional (Q1.(n-1)) multiplication.
package pmips_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_PASSB = 3'd4,
        OP_MUL   = 3'd5
    } op_t;

    // Largest positive Q1.(w-1) value, e.g. 0x7F for an 8-bit word.
    function automatic logic [63:0] q_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    localparam logic [N_DEF-1:0] Q_MAX = N_DEF'(q_max(N_DEF));

endpackage

// File: rtl/mul_seq.sv
// Sequential signed shift-add multiplier, one multiplier bit per cycle.
// The load cycle already consumes bit 0; the sign bit is subtracted last.
module mul_seq #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] product_q,
    output logic         ovf,
    output logic         done
);
    localparam int CW = $clog2(n + 1);

    logic [2*n-1:0] acc;
    logic [2*n-1:0] mcand;
    logic [n-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic [2*n-1:0] a_ext;

    assign a_ext = {{n{a[n-1]}}, a};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= b[0] ? a_ext : '0;
            mcand  <= a_ext << 1;
            mplier <= b >> 1;
            cnt    <= CW'(n - 1);
        end else if (cnt != '0) begin
            // The MSB of b carries negative weight in two's complement.
            if (mplier[0])
                acc <= (cnt == CW'(1)) ? acc - mcand : acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end

    // done marks the cycle whose closing edge performs the final iteration.
    assign done      = (cnt == CW'(1));
    assign product_q = acc[2*n-2:n-1];
    assign ovf       = acc[2*n-1] ^ acc[2*n-2];

endmodule

// File: rtl/alu_mul.sv
// Small ALU with registered result/zero and one-cycle write strobe.
// MUL (Q1.(n-1), sequential) exists only when ALU_MUL_EN is defined.
//
// state  | meaning
// IDLE   | accepts start; single-cycle ops complete at the accepting edge
// MUL    | multiplier iterating, busy high
// DONE   | product ready; result, zero and w update at the next edge
module alu_mul
    import pmips_pkg::*;
#(
    parameter int n = N_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] result,
    output logic         w,
    output logic         busy,
    output logic         zero
);
    logic [n-1:0] alu_val;
    logic         wr_en;
    logic [n-1:0] wr_val;

    always_comb begin
        alu_val = b;
        case (op_t'(op))
            OP_ADD:  alu_val = a + b;
            OP_SUB:  alu_val = a - b;
            OP_AND:  alu_val = a & b;
            OP_OR:   alu_val = a | b;
            default: alu_val = b;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    localparam logic [n-1:0] SAT = n'(q_max(n));

    state_t       state;
    state_t       state_nxt;
    logic         load;
    logic         mul_last;
    logic         mul_ovf;
    logic [n-1:0] mul_q;
    logic         is_mul;

    assign is_mul = (op_t'(op) == OP_MUL);

    mul_seq #(.n(n)) u_mul_seq (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .a         (a),
        .b         (b),
        .product_q (mul_q),
        .ovf       (mul_ovf),
        .done      (mul_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        wr_en     = 1'b0;
        wr_val    = alu_val;
        case (state)
            S_IDLE: begin
                if (start && is_mul) begin
                    load      = 1'b1;
                    state_nxt = S_MUL;
                end else if (start) begin
                    wr_en = 1'b1;
                end
            end
            S_MUL:   if (mul_last) state_nxt = S_DONE;
            S_DONE: begin
                wr_en     = 1'b1;
                // Only -1 * -1 overflows the fractional format.
                wr_val    = mul_ovf ? SAT : mul_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
`else
    assign wr_en  = start;
    assign wr_val = alu_val;
    assign busy   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b1;
            w      <= 1'b0;
        end else begin
            w <= wr_en;
            if (wr_en) begin
                result <= wr_val;
                zero   <= (wr_val == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_mul.sv
// Directed self-checking bench for alu_mul; MUL expectations switch on ALU_MUL_EN.
`timescale 1ns/1ps
module tb_alu_mul;
    import pmips_pkg::*;

    localparam int n = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [n-1:0] a = '0;
    logic [n-1:0] b = '0;
    logic [n-1:0] result;
    logic         w;
    logic         busy;
    logic         zero;

    int checks = 0;
    int failures = 0;

    alu_mul #(.n(n)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .w      (w),
        .busy   (busy),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [n-1:0] x, input logic [n-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
    endtask

`ifdef ALU_MUL_EN
    // Runs one MUL; optionally pulses an ADD start a few edges in.
    task automatic mul_run(input logic [n-1:0] x, input logic [n-1:0] y, input bit poke,
                           output int lat, output int busy_cnt, output int w_cnt);
        issue(OP_MUL, x, y);
        a = 8'h11;
        b = 8'h22;
        lat      = 0;
        busy_cnt = int'(busy);
        w_cnt    = int'(w);
        for (int k = 2; k <= 16; k++) begin
            if (poke && k == 4) begin
                @(negedge clk);
                start = 1'b1;
                op    = OP_ADD;
            end
            tick();
            start = 1'b0;
            busy_cnt += int'(busy);
            if (w) begin
                w_cnt++;
                if (lat == 0) lat = k;
            end
        end
    endtask
`endif

    initial begin
`ifdef ALU_MUL_EN
        int lat, bc, wc;
`endif
        #1 reset = 1'b1;
        #1;
        check("rst_result", 32'(result), 32'h0);
        check("rst_zero", 32'(zero), 32'h1);
        check("rst_w", 32'(w), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        issue(OP_ADD, 8'd10, 8'd11);
        check("add_result", 32'(result), 32'd21);
        check("add_w", 32'(w), 32'h1);
        check("add_zero", 32'(zero), 32'h0);
        tick();
        check("add_w_drop", 32'(w), 32'h0);
        check("add_hold", 32'(result), 32'd21);

        issue(OP_SUB, 8'd13, 8'd13);
        check("sub_eq_result", 32'(result), 32'h0);
        check("sub_eq_zero", 32'(zero), 32'h1);
        issue(OP_SUB, 8'd0, 8'd1);
        check("sub_wrap", 32'(result), 32'hFF);
        check("sub_wrap_zero", 32'(zero), 32'h0);
        issue(OP_ADD, 8'hF0, 8'h20);
        check("add_wrap", 32'(result), 32'h10);

        issue(OP_AND, 8'hF0, 8'h3C);
        check("and", 32'(result), 32'h30);
        issue(OP_OR, 8'hF0, 8'h0C);
        check("or", 32'(result), 32'hFC);
        issue(OP_PASSB, 8'h99, 8'h5A);
        check("passb", 32'(result), 32'h5A);
        issue(3'd6, 8'h01, 8'h33);
        check("op6_passb", 32'(result), 32'h33);
        issue(3'd7, 8'h44, 8'h00);
        check("op7_passb", 32'(result), 32'h00);
        check("op7_zero", 32'(zero), 32'h1);

`ifndef ALU_MUL_EN
        issue(OP_MUL, 8'd5, 8'd7);
        check("mul_off_result", 32'(result), 32'd7);
        check("mul_off_w", 32'(w), 32'h1);
        check("mul_off_busy", 32'(busy), 32'h0);
        tick();
        check("mul_off_busy2", 32'(busy), 32'h0);
`else
        mul_run(8'h40, 8'h40, 1'b0, lat, bc, wc);
        check("mul_4040", 32'(result), 32'h20);
        check("mul_4040_lat", 32'(lat), 32'd9);
        check("mul_4040_busy", 32'(bc), 32'd8);
        check("mul_4040_wcnt", 32'(wc), 32'd1);
        mul_run(8'hC0, 8'h40, 1'b0, lat, bc, wc);
        check("mul_c040", 32'(result), 32'hE0);
        check("mul_c040_zero", 32'(zero), 32'h0);
        mul_run(8'hC0, 8'hC0, 1'b0, lat, bc, wc);
        check("mul_c0c0", 32'(result), 32'h20);
        mul_run(8'h80, 8'h80, 1'b0, lat, bc, wc);
        check("mul_sat", 32'(result), 32'h7F);
        mul_run(8'h20, 8'h60, 1'b1, lat, bc, wc);
        check("mul_poke_result", 32'(result), 32'h18);
        check("mul_poke_wcnt", 32'(wc), 32'd1);
        check("mul_poke_lat", 32'(lat), 32'd9);

        issue(OP_MUL, 8'h40, 8'h40);
        tick();
        tick();
        tick();
        #1 reset = 1'b1;
        #1;
        check("mulrst_busy", 32'(busy), 32'h0);
        check("mulrst_result", 32'(result), 32'h0);
        check("mulrst_zero", 32'(zero), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        wc = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            wc += int'(w);
        end
        check("mulrst_no_w", 32'(wc), 32'd0);
`endif

        issue(OP_ADD, 8'd3, 8'd4);
        check("pre_rst_add", 32'(result), 32'd7);
        #1 reset = 1'b1;
        #1;
        check("async_rst_result", 32'(result), 32'h0);
        check("async_rst_zero", 32'(zero), 32'h1);
        check("async_rst_w", 32'(w), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        issue(OP_ADD, 8'd100, 8'd28);
        check("post_rst_add", 32'(result), 32'h80);
        check("post_rst_w", 32'(w), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
